// File: rtl/pellet_pkg.sv
// Shared constants for the live pellet map: geometry, the start-of-level pellet
// pattern (complement of the maze wall rows) and its total pellet count.
package pellet_pkg;

  localparam int DATA_WIDTH = 22;
  localparam int NUM_ROWS   = 19;
  localparam int ADDR_WIDTH = 5;
  localparam int COL_WIDTH  = 5;
  localparam int NUM_READ   = 4;
  localparam int CNT_WIDTH  = 9;

  typedef enum logic {INIT, RUN} state_t;

  // Row 9 is the side tunnel: no walls, so every column holds a pellet.
  localparam logic [DATA_WIDTH-1:0] INIT_MAP [NUM_ROWS] = '{
    ~22'h3FFFFF, ~22'h200001, ~22'h278079, ~22'h278079, ~22'h200001,
    ~22'h203F01, ~22'h203F01, ~22'h200001, ~22'h278079, ~22'h000000,
    ~22'h278079, ~22'h200001, ~22'h203F01, ~22'h203F01, ~22'h200001,
    ~22'h278079, ~22'h278079, ~22'h200001, ~22'h3FFFFF
  };

  function automatic int map_popcount();
    int n;
    n = 0;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < DATA_WIDTH; c++)
        n += int'(INIT_MAP[r][c]);
    return n;
  endfunction

  localparam logic [CNT_WIDTH-1:0] PELLET_TOTAL = CNT_WIDTH'(map_popcount());

endpackage

// File: rtl/pellet_map_ram_popcount_row.sv
// Combinational population count of one map row, used to build the pellet
// total while the map is being loaded.
module popcount_row
  import pellet_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] row_word,
  output logic [CNT_WIDTH-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      count = count + CNT_WIDTH'(row_word[i]);
  end

endmodule

// File: rtl/pellet_map_ram.sv
// Live pellet map: reloads from INIT_MAP after reset/restart, clears bits as
// pellets are eaten, tracks the remaining count and serves registered reads.
module pellet_map_ram
  import pellet_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 restart,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  r_row,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  r_data,
  input  logic                                 eat_valid,
  input  logic [ADDR_WIDTH-1:0]                eat_row,
  input  logic [COL_WIDTH-1:0]                 eat_col,
  output logic                                 eat_hit,
  output logic [CNT_WIDTH-1:0]                 pellets_left,
  output logic                                 all_eaten,
  output logic                                 ready
);

  localparam logic [ADDR_WIDTH-1:0] ROW_LIMIT = ADDR_WIDTH'(NUM_ROWS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [COL_WIDTH-1:0]  COL_LIMIT = COL_WIDTH'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [NUM_ROWS];

  state_t                state;
  logic [ADDR_WIDTH-1:0] row_idx;
  logic [DATA_WIDTH-1:0] init_word;
  logic [CNT_WIDTH-1:0]  row_pop;
  logic [DATA_WIDTH-1:0] eat_word;
  logic                  eat_ok;
  logic                  hit;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign init_word = (row_idx < ROW_LIMIT) ? INIT_MAP[row_idx] : '0;

  popcount_row u_popcount_row (
    .row_word (init_word),
    .count    (row_pop)
  );

  // restart outranks a same-cycle eat so a reload never races a clear.
  assign eat_ok   = ready && eat_valid && !restart &&
                    (eat_row < ROW_LIMIT) && (eat_col < COL_LIMIT);
  assign eat_word = (eat_row < ROW_LIMIT) ? mem[eat_row] : '0;
  assign hit      = eat_ok && eat_word[eat_col];

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = row_idx;
    mem_wdata = init_word;
    if (state == INIT && !restart) begin
      mem_we = 1'b1;
    end else if (hit) begin
      mem_we    = 1'b1;
      mem_waddr = eat_row;
      mem_wdata = eat_word & ~(DATA_WIDTH'(1) << eat_col);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= INIT;
      row_idx      <= '0;
      pellets_left <= '0;
      ready        <= 1'b0;
      eat_hit      <= 1'b0;
    end else begin
      eat_hit <= 1'b0;
      case (state)
        INIT: begin
          if (restart) begin
            row_idx      <= '0;
            pellets_left <= '0;
          end else begin
            pellets_left <= pellets_left + row_pop;
            if (row_idx == LAST_ROW) begin
              state   <= RUN;
              ready   <= 1'b1;
              row_idx <= '0;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        RUN: begin
          if (restart) begin
            state        <= INIT;
            row_idx      <= '0;
            pellets_left <= '0;
            ready        <= 1'b0;
          end else if (hit) begin
            eat_hit <= 1'b1;
            if (pellets_left != '0)
              pellets_left <= pellets_left - 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Reads sample mem before this edge's eat write lands (read-before-write).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else begin
      for (int p = 0; p < NUM_READ; p++)
        r_data[p] <= (ready && r_row[p] < ROW_LIMIT) ? mem[r_row[p]] : '0;
    end
  end

  assign all_eaten = ready && (pellets_left == '0);

endmodule

// File: doc/pellet_map_ram.md
Name: pellet_map_ram

Overview:
- Writable, multi-port successor to the static maze ROM. Holds the live pellet map as NUM_ROWS words of DATA_WIDTH bits, one bit per column (1 = pellet present).
- Loads itself from a package constant after reset or on restart, and clears bits as Pac-Man eats.
- Keeps a running pellet count. Feeds the renderer, the ghost/AI read ports and the score/level logic.

Parameters:
- DATA_WIDTH, 22, columns per row (bits per word)
- NUM_ROWS, 19, rows in the map (valid row addresses 0..NUM_ROWS-1)
- ADDR_WIDTH, 5, row address width
- COL_WIDTH, 5, column index width
- NUM_READ, 4, number of independent read ports
- CNT_WIDTH, 9, pellet counter width

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- restart  in  1  single-cycle request to reload the map from the initial pattern
- r_row  in  [NUM_READ][ADDR_WIDTH]  read row address per port
- r_data  out  [NUM_READ][DATA_WIDTH]  registered row word per port
- eat_valid  in  1  eat request strobe
- eat_row  in  ADDR_WIDTH  row to clear
- eat_col  in  COL_WIDTH  column to clear
- eat_hit  out  1  one-cycle pulse: the last accepted eat removed a pellet
- pellets_left  out  CNT_WIDTH  remaining pellets
- all_eaten  out  1  ready and pellets_left == 0
- ready  out  1  map loaded and accepting eats

Behaviour:
- FSM states: INIT and RUN.
- Reset (async, reset_n low): state=INIT, row_idx=0, pellets_left=0, r_data all 0, eat_hit=0, ready=0, all_eaten=0.
- INIT, each cycle:
  - mem[row_idx] <= INIT_MAP[row_idx]
  - pellets_left += popcount(INIT_MAP[row_idx])
  - row_idx++
  - After writing row NUM_ROWS-1 -> RUN, ready=1.
  - INIT lasts exactly NUM_ROWS cycles: ready is high on the NUM_ROWS-th rising edge after reset_n deasserts.
- RUN: restart -> INIT, with row_idx=0, pellets_left=0 and ready=0 on the next edge.
- restart while already in INIT: row_idx and pellets_left restart at 0, so the count is never doubled.
- Reads:
  - 1-cycle latency: r_data[p] at edge t+1 = mem[r_row[p]] sampled at edge t.
  - While not ready, or when r_row >= NUM_ROWS: r_data[p] <= 0.
  - All ports are independent; the same row on several ports is legal.
- Eats:
  - Accepted only when ready and eat_valid, with eat_row < NUM_ROWS and eat_col < DATA_WIDTH. All other requests are dropped with no state change and eat_hit=0.
  - Accepted and bit set: clear the bit, pellets_left -= 1, eat_hit=1 on the next cycle.
  - Accepted and bit already clear: no change, eat_hit=0.
  - pellets_left never wraps below 0.
- Read/eat collision: a read of the row being eaten in the same cycle returns the old word (read-before-write). A read one cycle later returns the cleared word.
- restart and eat_valid in the same cycle: restart wins and the eat is dropped.
- all_eaten is combinational from ready and pellets_left. It is 0 during INIT even though the count is 0 then.

Decomposition:
- Package pellet_pkg:
  - INIT_MAP, array [NUM_ROWS] of DATA_WIDTH words. Pellet bits are the complement of the wall ROM rows, tunnel row 9 included.
  - PELLET_TOTAL, the popcount of INIT_MAP.
  - State enum {INIT, RUN}.
- One natural sub-module, popcount_row: combinational DATA_WIDTH-bit population count used during INIT.

Test Plan:
- Reset release, then NUM_ROWS=19 idle cycles:
  - ready rises on edge 19, not before.
  - pellets_left == PELLET_TOTAL.
  - Read row 1 on port 0 -> r_data[0] == INIT_MAP[1] one cycle later.
- Eat of row 1, col 1 (pellet present):
  - eat_hit=1 for one cycle, pellets_left = PELLET_TOTAL-1.
  - Repeating the same eat -> eat_hit=0, count unchanged.
- Eat at row 1, col 1 and read of row 1 on ports 0..3 in the same cycle:
  - All four ports return the old word with bit 1 set.
  - Re-read next cycle -> bit 1 clear on every port.
- Dropped requests, each giving eat_hit=0, no count change and reads of 0 where applicable:
  - Eat with eat_row=19 or eat_col=22.
  - Eat during INIT.
  - Read of row 25.
- Eat every pellet from INIT_MAP:
  - all_eaten asserts on the cycle pellets_left reaches 0.
  - Further eats keep the count at 0.
- Cross-state restart and reset:
  - restart in RUN -> ready low for 19 cycles, then the map is fully restored and the count equals PELLET_TOTAL.
  - restart at INIT cycle 10 -> same final count, no doubling.
  - reset_n pulsed mid-INIT -> outputs clear asynchronously.
